// File: rtl/fb_access_sched_if.sv
// Framebuffer access bus: scanout read, draw write, clear control and RAM port.
// The scheduler takes the slave modport; the surrounding logic and RAM take master.
interface fb_access_sched_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
);
   logic              rd_req;
   logic [8:0]        rd_x;
   logic [8:0]        rd_y;
   logic              rd_valid;
   logic [PIX_W-1:0]  rd_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [8:0]        wr_x;
   logic [8:0]        wr_y;
   logic [PIX_W-1:0]  wr_data;
   logic              clr_start;
   logic [PIX_W-1:0]  clr_color;
   logic              clr_busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;

   modport slave (
      input  rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data,
             clr_start, clr_color, mem_rdata,
      output rd_valid, rd_data, wr_ready, clr_busy, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data,
             clr_start, clr_color, mem_rdata,
      input  rd_valid, rd_data, wr_ready, clr_busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/fb_access_sched.sv
// Framebuffer access scheduler: scanout read > clear engine > draw write on one RAM port.
// Optional FB_STATS_EN adds drop_cnt, a saturating count of dropped out-of-range writes.
//
// state    | meaning
// ST_IDLE  | no clear running; draw writes may be granted
// ST_CLEAR | filling the frame with the latched color, one pixel per free cycle
module fb_access_sched #(
   parameter int WIDTH  = 200,
   parameter int HEIGHT = 150,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FB_STATS_EN
   output logic [15:0] drop_cnt,
`endif
   fb_access_sched_if.slave bus
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam logic [8:0]        X_LIM    = 9'(WIDTH);
   localparam logic [8:0]        Y_LIM    = 9'(HEIGHT);
   localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [PIX_W-1:0]  clr_col;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [PIX_W-1:0]  mem_wdata;
   logic              rd_p1, rd_p1_inr, rd_p2, rd_p2_inr;
   logic              rd_valid;
   logic [PIX_W-1:0]  rd_data;

   logic [ADDR_W-1:0] rd_eff, wr_eff;
   logic              rd_inr, wr_inr, clr_busy, wr_ready;

   assign rd_eff = ADDR_W'(bus.rd_y) * WIDTH_A + ADDR_W'(bus.rd_x);
   assign wr_eff = ADDR_W'(bus.wr_y) * WIDTH_A + ADDR_W'(bus.wr_x);
   assign rd_inr = (bus.rd_x < X_LIM) && (bus.rd_y < Y_LIM);
   assign wr_inr = (bus.wr_x < X_LIM) && (bus.wr_y < Y_LIM);

   assign clr_busy = (state == ST_CLEAR);
   assign wr_ready = !bus.rd_req && !clr_busy;

   assign bus.clr_busy  = clr_busy;
   assign bus.wr_ready  = wr_ready;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_we    = mem_we;
   assign bus.mem_wdata = mem_wdata;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_data   = rd_data;

   // RAM port arbitration and clear FSM share one block since both steer mem_*.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         clr_cnt   <= '0;
         clr_col   <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         if (bus.rd_req) begin
            mem_addr <= rd_eff;
            mem_we   <= 1'b0;
         end else if (state == ST_CLEAR) begin
            mem_addr  <= clr_cnt;
            mem_wdata <= clr_col;
            mem_we    <= 1'b1;
            clr_cnt   <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_PIX)
               state <= ST_IDLE;
         end else if (bus.wr_valid && wr_inr) begin
            mem_addr  <= wr_eff;
            mem_wdata <= bus.wr_data;
            mem_we    <= 1'b1;
         end else begin
            mem_we <= 1'b0;
         end

         if (state == ST_IDLE && bus.clr_start) begin
            state   <= ST_CLEAR;
            clr_col <= bus.clr_color;
            clr_cnt <= '0;
         end
      end
   end

   // Out-of-range reads still flow down the pipe so scanout keeps a fixed latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_p1     <= 1'b0;
         rd_p1_inr <= 1'b0;
         rd_p2     <= 1'b0;
         rd_p2_inr <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_p1     <= bus.rd_req;
         rd_p1_inr <= rd_inr;
         rd_p2     <= rd_p1;
         rd_p2_inr <= rd_p1_inr;
         rd_valid  <= rd_p2;
         if (rd_p2)
            rd_data <= rd_p2_inr ? bus.mem_rdata : '0;
      end
   end

`ifdef FB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_cnt <= '0;
      else if (bus.wr_valid && wr_ready && !wr_inr && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fb_access_sched.sv
// Directed bench for fb_access_sched with a behavioural single-port synchronous RAM.
module tb_fb_access_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   fails = 0;

   logic [7:0]  ram [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   fb_access_sched_if #(.PIX_W(8), .ADDR_W(16)) bus ();

`ifdef FB_STATS_EN
   logic [15:0] drop_cnt;
`endif

   fb_access_sched dut (
      .clk(clk),
      .rst(rst),
`ifdef FB_STATS_EN
      .drop_cnt(drop_cnt),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (bus.mem_we)
         ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
      bus.wr_valid = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_data = 0;
      bus.clr_start = 0; bus.clr_color = 0;
      rst = 1'b1;
      preload(16'd2020, 8'hA5);
      preload(16'd30000, 8'hEE);
      preload(16'd1000, 8'hC1);
      preload(16'd1001, 8'hC2);
      preload(16'd1002, 8'hC3);
      tests_run++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %0h exp 0", bus.rd_valid); end
      tests_run++; if (bus.rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %0h exp 0", bus.rd_data); end
      tests_run++; if (bus.mem_addr !== 16'd0) begin fails++; $display("FAIL reset_mem_addr got %0d exp 0", bus.mem_addr); end
      tests_run++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %0h exp 0", bus.mem_we); end
      tests_run++; if (bus.mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata got %0h exp 0", bus.mem_wdata); end
      tests_run++; if (bus.clr_busy !== 1'b0) begin fails++; $display("FAIL reset_clr_busy got %0h exp 0", bus.clr_busy); end
      tests_run++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %0h exp 1", bus.wr_ready); end
`ifdef FB_STATS_EN
      tests_run++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
`endif
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      bus.rd_req = 1; bus.rd_x = 9'd20; bus.rd_y = 9'd10;
      tick();
      bus.rd_req = 0;
      tests_run++; if (bus.mem_addr !== 16'd2020) begin fails++; $display("FAIL read_addr got %0d exp 2020", bus.mem_addr); end
      tests_run++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL read_we got %0h exp 0", bus.mem_we); end
      tests_run++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_valid_k got %0h exp 0", bus.rd_valid); end
      tick();
      tests_run++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_valid_k1 got %0h exp 0", bus.rd_valid); end
      tick();
      tests_run++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL read_valid_k2 got %0h exp 1", bus.rd_valid); end
      tests_run++; if (bus.rd_data !== 8'hA5) begin fails++; $display("FAIL read_data got %0h exp a5", bus.rd_data); end
      tick();
      tests_run++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_valid_pulse got %0h exp 0", bus.rd_valid); end
   endtask

   task automatic test_write();
      bus.wr_valid = 1; bus.wr_x = 9'd199; bus.wr_y = 9'd149; bus.wr_data = 8'h3C;
      #1;
      tests_run++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL write_ready got %0h exp 1", bus.wr_ready); end
      tick();
      bus.wr_valid = 0;
      tests_run++; if (bus.mem_addr !== 16'd29999) begin fails++; $display("FAIL write_addr got %0d exp 29999", bus.mem_addr); end
      tests_run++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL write_we got %0h exp 1", bus.mem_we); end
      tests_run++; if (bus.mem_wdata !== 8'h3C) begin fails++; $display("FAIL write_wdata got %0h exp 3c", bus.mem_wdata); end
      tick();
      tests_run++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL write_we_drop got %0h exp 0", bus.mem_we); end
      tests_run++; if (ram[29999] !== 8'h3C) begin fails++; $display("FAIL write_ram got %0h exp 3c", ram[29999]); end
      bus.wr_valid = 1; bus.wr_x = 9'd0; bus.wr_y = 9'd1; bus.wr_data = 8'h11;
      tick();
      bus.wr_valid = 0;
      tests_run++; if (bus.mem_addr !== 16'd200) begin fails++; $display("FAIL write_row1_addr got %0d exp 200", bus.mem_addr); end
      tick();
   endtask

   task automatic test_priority();
      bus.rd_req = 1; bus.rd_x = 0; bus.rd_y = 0;
      bus.wr_valid = 1; bus.wr_x = 9'd1; bus.wr_y = 0; bus.wr_data = 8'h77;
      #1;
      tests_run++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL prio_ready got %0h exp 0", bus.wr_ready); end
      tick();
      bus.rd_req = 0;
      tests_run++; if (bus.mem_addr !== 16'd0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL prio_read got addr %0d we %0h exp addr 0 we 0", bus.mem_addr, bus.mem_we); end
      #1;
      tests_run++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL prio_ready2 got %0h exp 1", bus.wr_ready); end
      tick();
      bus.wr_valid = 0;
      tests_run++; if (bus.mem_addr !== 16'd1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h77) begin fails++; $display("FAIL prio_write got addr %0d we %0h data %0h exp 1 1 77", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
      tick(); tick(); tick();
   endtask

   task automatic test_out_of_range();
      bus.wr_valid = 1; bus.wr_x = 9'd200; bus.wr_y = 0; bus.wr_data = 8'h99;
      #1;
      tests_run++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL oor_wr_ready got %0h exp 1", bus.wr_ready); end
      tick();
      bus.wr_valid = 0;
      tests_run++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL oor_wr_we got %0h exp 0", bus.mem_we); end
`ifdef FB_STATS_EN
      tests_run++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL oor_drop_cnt got %0d exp 1", drop_cnt); end
`endif
      bus.rd_req = 1; bus.rd_x = 0; bus.rd_y = 9'd150;
      tick();
      bus.rd_req = 0;
      tick(); tick();
      tests_run++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL oor_rd_valid got %0h exp 1", bus.rd_valid); end
      tests_run++; if (bus.rd_data !== 8'h00) begin fails++; $display("FAIL oor_rd_data got %0h exp 0", bus.rd_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [0:2];
      exp_d[0] = 8'hC1; exp_d[1] = 8'hC2; exp_d[2] = 8'hC3;
      for (int i = 0; i < 5; i++) begin
         bus.rd_req = (i < 3); bus.rd_x = 9'(i); bus.rd_y = 9'd5;
         tick();
         if (i >= 2) begin
            tests_run++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d[i-2]) begin fails++; $display("FAIL b2b_%0d got valid %0h data %0h exp 1 %0h", i-2, bus.rd_valid, bus.rd_data, exp_d[i-2]); end
         end
      end
      bus.rd_req = 0;
      tick();
      tests_run++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got %0h exp 0", bus.rd_valid); end
   endtask

   task automatic test_clear();
      int cyc = 0;
      int errs = 0;
      int rdy = 0;
      int exp_a = 0;
      logic stall;
      bus.clr_color = 8'h00; bus.clr_start = 1;
      tick();
      bus.clr_start = 0;
      tests_run++; if (bus.clr_busy !== 1'b1) begin fails++; $display("FAIL clear_busy_start got %0h exp 1", bus.clr_busy); end
      bus.wr_valid = 1; bus.wr_x = 9'd5; bus.wr_y = 9'd5; bus.wr_data = 8'hFF;
      while (bus.clr_busy === 1'b1 && cyc < 31000) begin
         #1;
         if (bus.wr_ready !== 1'b0) rdy++;
         stall = (cyc == 500);
         bus.rd_req = stall; bus.rd_x = 0; bus.rd_y = 0;
         if (cyc == 1000) begin bus.clr_start = 1; bus.clr_color = 8'hAA; end
         tick();
         cyc++;
         bus.clr_start = 0; bus.rd_req = 0;
         if (stall) begin
            if (bus.mem_we !== 1'b0) errs++;
         end else begin
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'(exp_a) || bus.mem_wdata !== 8'h00) errs++;
            exp_a++;
         end
      end
      bus.wr_valid = 0;
      tests_run++; if (cyc != 30001) begin fails++; $display("FAIL clear_cycles got %0d exp 30001", cyc); end
      tests_run++; if (errs != 0) begin fails++; $display("FAIL clear_sequence got %0d bad cycles exp 0", errs); end
      tests_run++; if (rdy != 0) begin fails++; $display("FAIL clear_wr_ready got %0d ready cycles exp 0", rdy); end
      tick();
      tests_run++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL clear_after_we got %0h exp 0", bus.mem_we); end
      tests_run++; if (ram[2020] !== 8'h00 || ram[29999] !== 8'h00 || ram[1005] !== 8'h00) begin fails++; $display("FAIL clear_ram got %0h %0h %0h exp 0 0 0", ram[2020], ram[29999], ram[1005]); end
   endtask

   task automatic test_reset_abort();
      int nw = 0;
      bus.clr_color = 8'h55; bus.clr_start = 1;
      tick();
      bus.clr_start = 0;
      repeat (101) tick();
      tests_run++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'd100) begin fails++; $display("FAIL abort_progress got we %0h addr %0d exp 1 100", bus.mem_we, bus.mem_addr); end
      rst = 1'b1;
      #1;
      tests_run++; if (bus.clr_busy !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL abort_immediate got busy %0h we %0h exp 0 0", bus.clr_busy, bus.mem_we); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.mem_we !== 1'b0 || bus.clr_busy !== 1'b0) nw++;
      end
      tests_run++; if (nw != 0) begin fails++; $display("FAIL abort_no_writes got %0d active cycles exp 0", nw); end
      tests_run++; if (ram[99] !== 8'h55 || ram[100] !== 8'h00) begin fails++; $display("FAIL abort_ram got %0h %0h exp 55 0", ram[99], ram[100]); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_priority();
      test_out_of_range();
      test_back_to_back();
      test_clear();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
